// File: rtl/ffp_serial_reader.sv
// ffp_serial_reader
// Parallel-in / serial-out readout stage for the FFP register family.
// A WIDTH-bit word is captured on the load handshake and shifted out one bit
// per accepted serial transfer.
//
// Handshakes (both ports): a transfer happens at a rising clk edge where
// valid=1, ready=1 and enable=1. A producer holds valid and its data stable
// until the transfer completes. sout/sout_valid/sout_last never change while
// sout_ready=0.
//
// Optional feature, macro FFP_SERIAL_PARITY_EN: appends an even-parity bit
// (XOR of the captured word) after the data bits; the frame becomes WIDTH+1
// bits and only the parity bit carries sout_last.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   enable     in   global clock enable, 0 freezes all state
//   load_valid in   D holds a word to capture
//   load_ready out  idle and out of reset (combinational from state)
//   D          in   parallel word, sampled only at the load edge
//   sout       out  current serial bit
//   sout_valid out  sout holds a valid bit
//   sout_ready in   consumer accepts the current bit
//   sout_last  out  current bit ends the frame
//   busy       out  frame in progress
//   dbg_state  out  FSM state for checkers (0 IDLE, 1 SHIFT, 2 PAR)
module ffp_serial_reader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] D,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef FFP_SERIAL_PARITY_EN
    ,PAR  = 2'd2
`endif
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             sout_d, sout_valid_d, sout_last_d, busy_d;
  logic [WIDTH-1:0] shifted;
`ifdef FFP_SERIAL_PARITY_EN
  logic             par, par_d;
`endif

  // The bit presented on sout is always the head end of the shift register.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign load_ready = (state == IDLE) && reset;
  assign dbg_state  = state;
  assign shifted    = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

  always_comb begin
    state_d      = state;
    shreg_d      = shreg;
    cnt_d        = cnt;
    sout_d       = sout;
    sout_valid_d = sout_valid;
    sout_last_d  = sout_last;
    busy_d       = busy;
`ifdef FFP_SERIAL_PARITY_EN
    par_d        = par;
`endif
    if (enable) begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            state_d      = SHIFT;
            shreg_d      = D;
            cnt_d        = CW'(WIDTH - 1);
            sout_d       = head_bit(D);
            sout_valid_d = 1'b1;
            sout_last_d  = 1'b0;  // WIDTH >= 2, so the first bit is never last
            busy_d       = 1'b1;
`ifdef FFP_SERIAL_PARITY_EN
            par_d        = ^D;
`endif
          end
        end
        SHIFT: begin
          if (sout_ready) begin
            if (cnt == '0) begin
`ifdef FFP_SERIAL_PARITY_EN
              state_d     = PAR;
              sout_d      = par;
              sout_last_d = 1'b1;
`else
              state_d      = IDLE;
              sout_d       = 1'b0;
              sout_valid_d = 1'b0;
              sout_last_d  = 1'b0;
              busy_d       = 1'b0;
`endif
            end else begin
              shreg_d = shifted;
              cnt_d   = cnt - CW'(1);
              sout_d  = head_bit(shifted);
`ifdef FFP_SERIAL_PARITY_EN
              sout_last_d = 1'b0;
`else
              // The bit moving onto sout is final when the counter lands on 0.
              sout_last_d = (cnt == CW'(1));
`endif
            end
          end
        end
`ifdef FFP_SERIAL_PARITY_EN
        PAR: begin
          if (sout_ready) begin
            state_d      = IDLE;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
            sout_last_d  = 1'b0;
            busy_d       = 1'b0;
          end
        end
`endif
        default: begin
          state_d      = IDLE;
          sout_valid_d = 1'b0;
          sout_last_d  = 1'b0;
          busy_d       = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
      busy       <= 1'b0;
`ifdef FFP_SERIAL_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      cnt        <= cnt_d;
      sout       <= sout_d;
      sout_valid <= sout_valid_d;
      sout_last  <= sout_last_d;
      busy       <= busy_d;
`ifdef FFP_SERIAL_PARITY_EN
      par        <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_ffp_serial_reader.sv
// Bench for ffp_serial_reader: an MSB-first and an LSB-first instance share
// all stimulus. A frame-level reference model pushes the expected serial bits
// of each accepted word into per-instance queues; a negedge monitor compares
// and pops them as the consumer accepts bits.
module tb_ffp_serial_reader;

  localparam int W = 4;
`ifdef FFP_SERIAL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = W + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         load_valid;
  logic [W-1:0] D;
  logic         sout_ready;

  logic         m_load_ready, m_sout, m_valid, m_last, m_busy;
  logic         l_load_ready, l_sout, l_valid, l_last, l_busy;
  logic [1:0]   m_dbg, l_dbg;

  int tests = 0;
  int fails = 0;
  int rem   = 0;

  // Each entry: {expected bit, expected last}.
  logic [1:0] exp_q_msb[$];
  logic [1:0] exp_q_lsb[$];

  always #5 clk = ~clk;

  ffp_serial_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(m_load_ready), .D(D), .sout(m_sout), .sout_valid(m_valid),
    .sout_ready(sout_ready), .sout_last(m_last), .busy(m_busy),
    .dbg_state(m_dbg));

  ffp_serial_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(l_load_ready), .D(D), .sout(l_sout), .sout_valid(l_valid),
    .sout_ready(sout_ready), .sout_last(l_last), .busy(l_busy),
    .dbg_state(l_dbg));

  task automatic chk(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame contents from the word: data bits in transmit order, then parity.
  task automatic push_frame(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      logic lastb;
      lastb = (i == W - 1) && !PAR;
      exp_q_msb.push_back({d[W-1-i], lastb});
      exp_q_lsb.push_back({d[i], lastb});
    end
    if (PAR) begin
      exp_q_msb.push_back({^d, 1'b1});
      exp_q_lsb.push_back({^d, 1'b1});
    end
  endtask

  // Reference model: idle when no bits remain; a word is taken only then.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem = 0;
      exp_q_msb.delete();
      exp_q_lsb.delete();
    end else if (enable) begin
      if (rem == 0) begin
        if (load_valid) begin
          push_frame(D);
          rem = FRAME;
        end
      end else if (sout_ready) begin
        rem = rem - 1;
      end
    end
  end

  // Monitor: check the presented bit, pop when it will be accepted.
  always @(negedge clk) begin
    chk("m_load_ready", m_load_ready, reset && (rem == 0));
    chk("l_load_ready", l_load_ready, reset && (rem == 0));
    chk("m_valid", m_valid, exp_q_msb.size() != 0);
    chk("l_valid", l_valid, exp_q_lsb.size() != 0);
    chk("m_busy", m_busy, rem != 0);
    chk("l_busy", l_busy, rem != 0);
    if (exp_q_msb.size() != 0) begin
      chk("m_bit", m_sout, exp_q_msb[0][1]);
      chk("m_last", m_last, exp_q_msb[0][0]);
      if (sout_ready && enable && reset) void'(exp_q_msb.pop_front());
    end
    if (exp_q_lsb.size() != 0) begin
      chk("l_bit", l_sout, exp_q_lsb[0][1]);
      chk("l_last", l_last, exp_q_lsb[0][0]);
      if (sout_ready && enable && reset) void'(exp_q_lsb.pop_front());
    end
  end

  task automatic drive(input logic lv, input logic [W-1:0] d,
                       input logic rdy, input logic en);
    load_valid = lv;
    D          = d;
    sout_ready = rdy;
    enable     = en;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_sout"}, m_sout, 1'b0);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_last"}, m_last, 1'b0);
    chk({tag, "_m_busy"}, m_busy, 1'b0);
    chk({tag, "_m_load_ready"}, m_load_ready, 1'b0);
    chk({tag, "_l_valid"}, l_valid, 1'b0);
    chk({tag, "_l_busy"}, l_busy, 1'b0);
  endtask

  initial begin
    reset      = 1'b0;
    enable     = 1'b1;
    load_valid = 1'b0;
    D          = '0;
    sout_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_outputs("por");
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame.
    drive(1'b1, 4'b1011, 1'b1, 1'b1);
    idle(5);

    // Backpressure after the first bit.
    drive(1'b1, 4'b0110, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b1);
    idle(6);

    // Enable freeze after two bits, with load_valid asserted meanwhile.
    drive(1'b1, 4'b1001, 1'b1, 1'b1);
    idle(2);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'b1111, 1'b1, 1'b0);
    idle(5);

    // Asynchronous reset after one bit.
    drive(1'b1, 4'b1111, 1'b1, 1'b1);
    idle(1);
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 4'b0001, 1'b1, 1'b1);
    idle(6);

    // D changes right after the load edge.
    drive(1'b1, 4'b0010, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 4'b1111, 1'b1, 1'b1);

    // Parity-relevant words (odd and even weight).
    drive(1'b1, 4'b0111, 1'b1, 1'b1);
    idle(6);
    drive(1'b1, 4'b0011, 1'b1, 1'b1);
    idle(6);

    // Back-to-back request: load_valid held high across frames.
    for (int i = 0; i < 12; i++) drive(1'b1, W'($urandom_range(0, 15)), 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0));

    // Drain and confirm every expected bit was seen.
    idle(FRAME + 3);
    chk("drain_msb_empty", exp_q_msb.size() == 0, 1'b1);
    chk("drain_lsb_empty", exp_q_lsb.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ffp_serial_reader.md
Name: ffp_serial_reader

Overview:
- Readout end of the team's enable-gated parallel flip-flop registers (FFP1/FFP2/FFP4 family).
- Captures a WIDTH-bit parallel word through a valid/ready load handshake, then shifts it out one bit per accepted transfer on a valid/ready serial port.
- Sits between a parallel register bank and any downstream bit-serial consumer.
- Shares the global clock-enable semantics of the FFP registers.

Parameters:
- WIDTH, 4, data word width; legal range 2..16.
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset: 0 resets immediately, 1 = run.
- enable  input  1  global clock enable; 0 freezes all state.
- load_valid  input  1  parallel word on D is valid.
- load_ready  output  1  block can accept a word.
- D  input  WIDTH  parallel data word.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout holds a valid bit.
- sout_ready  input  1  consumer accepts the current bit.
- sout_last  output  1  current bit is the final bit of the frame.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit counter=0.
  - Outputs during reset: load_ready=0, sout=0, sout_valid=0, sout_last=0, busy=0.
  - load_ready rises in the first cycle after reset deasserts.
- All outputs are registered except load_ready, which is decoded combinationally from state only (load_ready = state==IDLE && reset==1).
- States:
  - IDLE: load_ready=1, sout_valid=0.
  - SHIFT: sout_valid=1.
  - PAR: only present with the optional feature; sout_valid=1.
- Load: at a rising edge with enable=1, state=IDLE and load_valid=1:
  - D is captured and the counter is set to WIDTH-1.
  - The block enters SHIFT.
  - The first bit appears on sout with sout_valid=1 in the next cycle (1-cycle latency).
  - D is sampled only at this edge; later changes to D have no effect.
- Shift: at a rising edge with enable=1, state=SHIFT and sout_ready=1, the current bit is consumed.
  - MSB_FIRST=1: shift left.
  - MSB_FIRST=0: shift right.
  - Vacated bit positions fill with 0.
  - The counter decrements.
- sout_last=1 while the counter is 0 in SHIFT; it is also 1 throughout PAR.
- End of frame: acceptance of the last bit returns the block to IDLE; sout_valid=0 on the next cycle.
  - A new load requires at least one IDLE cycle, so back-to-back frames are separated by exactly one gap cycle.
- Backpressure: while sout_ready=0, sout, sout_valid and sout_last hold their values indefinitely.
- enable=0:
  - No load, no shift and no state change.
  - All outputs hold their current values (sout_valid stays 1 mid-frame).
  - load_ready still reflects the state; a handshake only completes when enable=1.
- Simultaneous load_valid during SHIFT: ignored, because load_ready=0.
- Reset mid-frame: the frame is aborted immediately and no partial data is retained.
- The counter is sized to hold WIDTH-1. There is no wrap-around; the counter never underflows because SHIFT exits at 0.

Optional Feature:
- Macro: FFP_SERIAL_PARITY_EN.
- Defined:
  - Even parity of the captured word (XOR of all D bits) is latched at load.
  - After the last data bit is accepted, the block enters PAR and drives sout=parity, sout_valid=1, sout_last=1.
  - Data bits carry sout_last=0.
  - Acceptance of the parity bit returns the block to IDLE.
  - A frame is WIDTH+1 bits.
- Undefined: no PAR state and no parity logic; a frame is WIDTH bits and sout_last marks the final data bit.

Test Plan:
- Basic frame, WIDTH=4, MSB_FIRST=1, sout_ready=1, enable=1: load D=4'b1011 → sout sequence 1,0,1,1 on 4 consecutive cycles starting 1 cycle after load; sout_last=1 only on the 4th bit; load_ready=1 again the cycle after.
- Backpressure: load D=4'b0110, hold sout_ready=0 for 3 cycles after the first bit → sout stays 0 with sout_valid=1; after release, the sequence continues 1,1,0 with no bit lost or duplicated.
- Enable freeze: mid-frame, after 2 bits of 4'b1001, drive enable=0 for 4 cycles with sout_ready=1 → outputs frozen at the 3rd bit (0); with enable=1 the sequence resumes 0,1; load_valid during the freeze is not accepted.
- Asynchronous reset mid-frame: drop reset to 0 between clock edges after 1 bit of 4'b1111 → sout, sout_valid and busy go to 0 immediately; after release load_ready=1 and a fresh load of 4'b0001 shifts out 0,0,0,1.
- LSB-first with D change: MSB_FIRST=0, load D=4'b0010, change D to 4'b1111 on the following cycle → sout 0,1,0,0.
- Parity (FFP_SERIAL_PARITY_EN defined): load 4'b0111 → sout 0,1,1,1 then parity 1 with sout_last=1 on the 5th bit only; load 4'b0011 → parity bit 0.
